seq_match_ctrl: RTL and testbench
=================================

SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001 Parameters: SEQ_ADDR_W, 4, address width (max sequence length 2**SEQ_ADDR_W = 16).
REQ-002 Parameters: TIMEOUT_TICKS, 10, TickEn pulses allowed per entry before timeout (>=1).
REQ-003 Clk  in  1  clock; all state changes on rising edge.
REQ-004 Rst  in  1  reset, synchronous, active-high.
REQ-005 BtnPulse  in  4  one-cycle press pulses from four button shapers; bit i = colour code i.
REQ-006 Start  in  1  one-cycle pulse that begins an entry round.
REQ-007 SeqLen  in  SEQ_ADDR_W+1  number of codes to match, 1..16; sampled only on accepted Start.
REQ-008 TickEn  in  1  one-cycle time-base enable, nominally 1 Hz.
REQ-009 MemAddr  out  SEQ_ADDR_W  registered read address into the sequence memory.
REQ-010 MemData  in  2  expected code, valid exactly one cycle after MemAddr changes.
REQ-011 Busy  out  1  high in every state except IDLE.
REQ-012 Progress  out  SEQ_ADDR_W+1  number of codes matched so far this round.
REQ-013 Match, Mismatch, Timeout  out  1 each  one-cycle result pulses, mutually exclusive.

Function
REQ-014 FSM states: IDLE, FETCH, LATCH, WAIT_BTN; all outputs registered.
REQ-015 IDLE: Start=1 with SeqLen in 1..16 -> Idx<=0, MemAddr<=0, TickCnt<=0, Progress<=0, LenReg<=SeqLen, next FETCH.
REQ-016 IDLE: Start with SeqLen=0 or SeqLen>16 ignored; state stays IDLE, no pulse.
REQ-017 Start while Busy=1 is ignored.
REQ-018 FETCH: one cycle, memory latency; next LATCH.
REQ-019 LATCH: Expected<=MemData; next WAIT_BTN; Start-to-first-accepting-cycle latency = 3 clocks.
REQ-020 WAIT_BTN, exactly one BtnPulse bit set, code==Expected, Idx<LenReg-1 -> Idx+1, MemAddr+1, Progress+1, TickCnt<=0, next FETCH.
REQ-021 WAIT_BTN, exactly one bit set, code==Expected, Idx==LenReg-1 -> Progress+1, Match=1 next cycle, next IDLE.
REQ-022 WAIT_BTN, one bit set with wrong code, or two or more bits set in same cycle -> Mismatch=1 next cycle, next IDLE; Progress holds.
REQ-023 WAIT_BTN, no bit set, TickEn=1 -> TickCnt+1; when TickCnt==TIMEOUT_TICKS-1 at that TickEn -> Timeout=1 next cycle, next IDLE.
REQ-024 Button pulse and TickEn in same WAIT_BTN cycle: button evaluated, tick discarded.
REQ-025 BtnPulse during IDLE, FETCH or LATCH is discarded without effect.
REQ-026 MemAddr does not wrap within a round; 16-code round ends at MemAddr=15.
REQ-027 Progress holds its final value in IDLE until the next accepted Start.

Reset
REQ-028 Rst=1 at any clock, including mid-round -> state IDLE, MemAddr=0, Progress=0, Idx=0, TickCnt=0, Expected=0, Busy=0, Match=Mismatch=Timeout=0.
REQ-029 Rst takes priority over Start, BtnPulse and TickEn in the same cycle.

Configuration
REQ-030 Macro SEQ_MATCH_TIMEOUT_EN defined: TickEn, TickCnt and Timeout behave per REQ-023/024.
REQ-031 Macro absent: TickCnt not built, TickEn ignored, Timeout tied 0, WAIT_BTN waits indefinitely.

Structure
REQ-032 Package seq_game_pkg holds FSM state encoding, CODE_W=2, NUM_BTN=4, and the result-code constants.
REQ-033 Sub-module btn_onehot_enc: combinational 4-bit pulse to {valid, multi, code[1:0]}; instantiated once.

Verification
REQ-034 SeqLen=3, memory {2,0,3}, pulses bit2, bit0, bit3 -> Progress 1,2,3; Match one cycle after third pulse; Busy low.
REQ-035 SeqLen=3, memory {2,0,3}, pulses bit2 then bit1 -> Mismatch one cycle later; Progress=1; MemAddr=1.
REQ-036 WAIT_BTN, BtnPulse=4'b0101 -> Mismatch; pulse during FETCH -> no effect, Progress unchanged.
REQ-037 SEQ_MATCH_TIMEOUT_EN defined, TIMEOUT_TICKS=10, no pulses, 10 TickEn -> Timeout after 10th; TickEn coinciding with a correct pulse -> no timeout.
REQ-038 Rst asserted at Progress=2 of SeqLen=5 -> all outputs zero next cycle; new Start with SeqLen=1 and correct pulse -> Match.
REQ-039 Start with SeqLen=0, and Start while Busy -> ignored; SeqLen=16, all correct -> Match, MemAddr=15, Progress=16.

Source files
------------

// File: rtl/seq_game_pkg.sv
// Shared constants for the colour-sequence game: FSM encoding, code widths
// and the per-cycle result codes of the entry comparator.
package seq_game_pkg;

  localparam int CODE_W  = 2;
  localparam int NUM_BTN = 4;

  typedef logic [CODE_W-1:0] code_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FETCH    = 2'd1;
  localparam logic [1:0] ST_LATCH    = 2'd2;
  localparam logic [1:0] ST_WAIT_BTN = 2'd3;

  localparam logic [2:0] RES_NONE     = 3'd0;
  localparam logic [2:0] RES_ADVANCE  = 3'd1;
  localparam logic [2:0] RES_MATCH    = 3'd2;
  localparam logic [2:0] RES_MISMATCH = 3'd3;
  localparam logic [2:0] RES_TIMEOUT  = 3'd4;

endpackage

// File: rtl/btn_onehot_enc.sv
// Classifies the four button pulses of one cycle: exactly one press (valid,
// with its colour code) or two or more simultaneous presses (multi).
module btn_onehot_enc
  import seq_game_pkg::*;
(
  input  logic [NUM_BTN-1:0] pulse,
  output logic               valid,
  output logic               multi,
  output code_t              code
);

  logic [2:0] cnt;

  // Population count and priority-free code lookup for a single press
  always_comb begin
    cnt = 3'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt = cnt + {2'b00, pulse[i]};
    end
    valid = (cnt == 3'd1);
    multi = (cnt > 3'd1);
    case (pulse)
      4'b0010: code = 2'd1;
      4'b0100: code = 2'd2;
      4'b1000: code = 2'd3;
      default: code = 2'd0;
    endcase
  end

endmodule

// File: rtl/seq_match_ctrl.sv
// Steps through a stored colour sequence and checks each button press.
// Per-entry timeout on TickEn is built only when SEQ_MATCH_TIMEOUT_EN is defined.
module seq_match_ctrl
  import seq_game_pkg::*;
#(
  parameter int SEQ_ADDR_W    = 4,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NUM_BTN-1:0]    BtnPulse,
  input  logic                  Start,
  input  logic [SEQ_ADDR_W:0]   SeqLen,
  input  logic                  TickEn,
  output logic [SEQ_ADDR_W-1:0] MemAddr,
  input  logic [CODE_W-1:0]     MemData,
  output logic                  Busy,
  output logic [SEQ_ADDR_W:0]   Progress,
  output logic                  Match,
  output logic                  Mismatch,
  output logic                  Timeout
);

  localparam logic [SEQ_ADDR_W:0]   MAX_LEN = {1'b1, {SEQ_ADDR_W{1'b0}}};
  localparam logic [SEQ_ADDR_W:0]   ONE_L   = {{SEQ_ADDR_W{1'b0}}, 1'b1};
  localparam logic [SEQ_ADDR_W-1:0] ONE_A   = {{(SEQ_ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]          state_r;
  logic [SEQ_ADDR_W:0] len_r;
  code_t               expected_r;
  logic                btn_valid_s;
  logic                btn_multi_s;
  code_t               btn_code_s;
  logic                start_ok_s;
  logic                last_s;
  logic [2:0]          res_s;

`ifdef SEQ_MATCH_TIMEOUT_EN
  localparam int              TICK_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMEOUT_TICKS - 1);
  logic [TICK_W-1:0] tick_r;
`else
  localparam int unused_timeout_ticks = TIMEOUT_TICKS;
  logic unused_tick_s;
  assign unused_tick_s = TickEn;
  assign Timeout       = 1'b0;
`endif

  btn_onehot_enc u_enc (
    .pulse (BtnPulse),
    .valid (btn_valid_s),
    .multi (btn_multi_s),
    .code  (btn_code_s)
  );

  // MemAddr doubles as the entry index, so the final entry is len-1
  assign start_ok_s = Start && (SeqLen != '0) && (SeqLen <= MAX_LEN);
  assign last_s     = ({1'b0, MemAddr} == (len_r - ONE_L));

  // Per-cycle verdict in WAIT_BTN; a press always outranks a coinciding tick
  always_comb begin
    res_s = RES_NONE;
    if (state_r != ST_WAIT_BTN) begin
      res_s = RES_NONE;
    end else if (btn_valid_s && (btn_code_s == expected_r)) begin
      res_s = last_s ? RES_MATCH : RES_ADVANCE;
    end else if (btn_valid_s || btn_multi_s) begin
      res_s = RES_MISMATCH;
`ifdef SEQ_MATCH_TIMEOUT_EN
    end else if (TickEn && (tick_r == TICK_LAST)) begin
      res_s = RES_TIMEOUT;
`endif
    end else begin
      res_s = RES_NONE;
    end
  end

  // Round sequencing, registered outputs and one-cycle result pulses
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r    <= ST_IDLE;
      len_r      <= '0;
      expected_r <= '0;
      MemAddr    <= '0;
      Progress   <= '0;
      Busy       <= 1'b0;
      Match      <= 1'b0;
      Mismatch   <= 1'b0;
`ifdef SEQ_MATCH_TIMEOUT_EN
      tick_r     <= '0;
      Timeout    <= 1'b0;
`endif
    end else begin
      Match    <= 1'b0;
      Mismatch <= 1'b0;
`ifdef SEQ_MATCH_TIMEOUT_EN
      Timeout  <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            state_r  <= ST_FETCH;
            len_r    <= SeqLen;
            MemAddr  <= '0;
            Progress <= '0;
            Busy     <= 1'b1;
`ifdef SEQ_MATCH_TIMEOUT_EN
            tick_r   <= '0;
`endif
          end
        end
        ST_FETCH: state_r <= ST_LATCH;
        ST_LATCH: begin
          expected_r <= MemData;
          state_r    <= ST_WAIT_BTN;
        end
        ST_WAIT_BTN: begin
          case (res_s)
            RES_ADVANCE: begin
              MemAddr  <= MemAddr + ONE_A;
              Progress <= Progress + ONE_L;
              state_r  <= ST_FETCH;
`ifdef SEQ_MATCH_TIMEOUT_EN
              tick_r   <= '0;
`endif
            end
            RES_MATCH: begin
              Progress <= Progress + ONE_L;
              Match    <= 1'b1;
              Busy     <= 1'b0;
              state_r  <= ST_IDLE;
            end
            RES_MISMATCH: begin
              Mismatch <= 1'b1;
              Busy     <= 1'b0;
              state_r  <= ST_IDLE;
            end
            RES_TIMEOUT: begin
`ifdef SEQ_MATCH_TIMEOUT_EN
              Timeout  <= 1'b1;
`endif
              Busy     <= 1'b0;
              state_r  <= ST_IDLE;
            end
            default: begin
`ifdef SEQ_MATCH_TIMEOUT_EN
              if (TickEn) tick_r <= tick_r + 1'b1;
`endif
            end
          endcase
        end
        default: begin
          state_r <= ST_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl; timeout cases follow SEQ_MATCH_TIMEOUT_EN.
module tb_seq_match_ctrl;

  localparam int AW = 4;
  localparam int TO = 10;
`ifdef SEQ_MATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [3:0]    BtnPulse = 4'b0;
  logic          Start = 1'b0;
  logic [AW:0]   SeqLen = '0;
  logic          TickEn = 1'b0;
  logic [AW-1:0] MemAddr;
  logic [1:0]    MemData;
  logic          Busy;
  logic [AW:0]   Progress;
  logic          Match, Mismatch, Timeout;

  seq_match_ctrl #(.SEQ_ADDR_W(AW), .TIMEOUT_TICKS(TO)) dut (
    .Clk(Clk), .Rst(Rst), .BtnPulse(BtnPulse), .Start(Start), .SeqLen(SeqLen),
    .TickEn(TickEn), .MemAddr(MemAddr), .MemData(MemData), .Busy(Busy),
    .Progress(Progress), .Match(Match), .Mismatch(Mismatch), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read sequence memory: data valid one cycle after the address
  logic [1:0] mem [16];
  always_ff @(posedge Clk) MemData <= mem[MemAddr];

  typedef struct {
    logic        match, mismatch, timeout, busy;
    logic [AW:0] prog;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_prog = 0, m_idx = 0, m_len = 0, m_tick = 0;
  bit m_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit mt, input bit mm, input bit to);
    exp_t e;
    e.match = mt; e.mismatch = mm; e.timeout = to; e.busy = m_busy;
    e.prog = m_prog[AW:0]; e.addr = m_idx[AW-1:0];
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".match"},    Match,    e.match);
    chk({tag, ".mismatch"}, Mismatch, e.mismatch);
    chk({tag, ".timeout"},  Timeout,  e.timeout);
    chk({tag, ".busy"},     Busy,     e.busy);
    chk({tag, ".progress"}, Progress, e.prog);
    chk({tag, ".memaddr"},  MemAddr,  e.addr);
  endtask

  task automatic do_reset(input string tag, input int gap, input logic [3:0] b);
    repeat (gap) @(negedge Clk);
    Rst = 1'b1; BtnPulse = b; Start = 1'b1; SeqLen = 5'd5; TickEn = 1'b1;
    m_prog = 0; m_idx = 0; m_tick = 0; m_busy = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    Rst = 1'b0; BtnPulse = 4'b0; Start = 1'b0; TickEn = 1'b0;
    compare_out(tag);
  endtask

  task automatic do_start(input string tag, input int len);
    @(negedge Clk);
    Start = 1'b1; SeqLen = len[AW:0];
    if (!m_busy && len >= 1 && len <= 16) begin
      m_busy = 1'b1; m_idx = 0; m_prog = 0; m_len = len; m_tick = 0;
    end
    push_exp(1'b0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    Start = 1'b0;
    compare_out(tag);
  endtask

  task automatic press(input string tag, input int gap, input logic [3:0] b, input bit tk);
    int cnt, code;
    repeat (gap) @(negedge Clk);
    BtnPulse = b; TickEn = tk;
    cnt = $countones(b);
    code = 0;
    for (int i = 0; i < 4; i++) if (b[i]) code = i;
    if (cnt == 1 && code == int'(mem[m_idx])) begin
      m_prog++;
      m_tick = 0;
      if (m_idx == m_len - 1) begin
        m_busy = 1'b0;
        push_exp(1'b1, 1'b0, 1'b0);
      end else begin
        m_idx++;
        push_exp(1'b0, 1'b0, 1'b0);
      end
    end else begin
      m_busy = 1'b0;
      push_exp(1'b0, 1'b1, 1'b0);
    end
    @(posedge Clk); #1;
    BtnPulse = 4'b0; TickEn = 1'b0;
    compare_out(tag);
  endtask

  task automatic early_pulse(input string tag, input logic [3:0] b);
    @(negedge Clk);
    BtnPulse = b;
    push_exp(1'b0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    BtnPulse = 4'b0;
    compare_out(tag);
  endtask

  task automatic tick(input string tag, input int gap);
    bit to;
    repeat (gap) @(negedge Clk);
    TickEn = 1'b1;
    to = 1'b0;
    if (TO_EN) begin
      m_tick++;
      if (m_tick == TO) begin
        to = 1'b1;
        m_busy = 1'b0;
      end
    end
    push_exp(1'b0, 1'b0, to);
    @(posedge Clk); #1;
    TickEn = 1'b0;
    compare_out(tag);
  endtask

  task automatic idle_cycle(input string tag);
    push_exp(1'b0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    compare_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    repeat (3) @(posedge Clk);
    do_reset("reset", 1, 4'b0000);

    // Basic three-code match
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    do_start("s3a", 3);
    press("m1", 3, 4'b0100, 1'b0);
    press("m2", 3, 4'b0001, 1'b0);
    press("m3", 3, 4'b1000, 1'b0);
    idle_cycle("after_match");

    // Wrong second code
    do_start("s3b", 3);
    press("w1", 3, 4'b0100, 1'b0);
    press("w2", 3, 4'b0010, 1'b0);

    // Two buttons at once, then a press during FETCH
    do_start("s3c", 3);
    press("multi", 3, 4'b0101, 1'b0);
    do_start("s3d", 3);
    press("f1", 3, 4'b0100, 1'b0);
    early_pulse("fetch_pulse", 4'b0010);
    press("f2", 2, 4'b0001, 1'b0);
    press("f3", 3, 4'b1000, 1'b0);

    // Illegal lengths and Start while busy
    do_start("len0", 0);
    do_start("len17", 17);
    do_start("s3e", 3);
    do_start("busy_start", 1);
    press("b1", 2, 4'b0100, 1'b0);
    press("b2", 3, 4'b0010, 1'b0);

    // Full-length round
    for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
    do_start("s16", 16);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] b;
      b = 4'b0001 << mem[i];
      press($sformatf("full%0d", i), 3, b, 1'b0);
    end

    // Reset mid-round with competing inputs, then a one-code round
    mem[0] = 2'd1; mem[1] = 2'd2; mem[2] = 2'd3; mem[3] = 2'd0; mem[4] = 2'd1;
    do_start("s5", 5);
    press("r1", 3, 4'b0010, 1'b0);
    press("r2", 3, 4'b0100, 1'b0);
    do_reset("mid_reset", 3, 4'b1000);
    mem[0] = 2'd2;
    do_start("s1", 1);
    press("one", 3, 4'b0100, 1'b0);

    // Timeout after TO ticks of inactivity (no timeout when not built)
    mem[0] = 2'd1; mem[1] = 2'd3;
    do_start("s2a", 2);
    for (int i = 0; i < TO; i++) tick($sformatf("tick%0d", i), (i == 0) ? 3 : 1);
    idle_cycle("after_timeout");
    do_reset("post_tick_reset", 1, 4'b0000);

    // Tick coinciding with a correct press restarts the count
    do_start("s2b", 2);
    for (int i = 0; i < TO - 1; i++) tick($sformatf("pre%0d", i), (i == 0) ? 3 : 1);
    press("tick_press", 1, 4'b0010, 1'b1);
    for (int i = 0; i < TO - 1; i++) tick($sformatf("post%0d", i), (i == 0) ? 3 : 1);
    press("tick_final", 1, 4'b1000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
